// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder: field-width helpers,
// special-case tags and the canonical quiet-NaN encoding.
package fp_pkg;

    typedef enum logic [1:0] {
        NORM,
        ZERO,
        INF,
        QNAN
    } fp_tag_e;

    function automatic int unsigned BIAS(int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned W(int unsigned exp_w, int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Positive sign, all-ones exponent, only the fraction MSB set.
    function automatic logic [63:0] qnan_word(int unsigned exp_w, int unsigned man_w);
        logic [63:0] q;
        q = ((64'd1 << exp_w) - 64'd1) << man_w;
        q = q | (64'd1 << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; cnt_o equals WIDTH when the input is all zero.
module fp_lzc #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    always_comb begin
        cnt_o  = CNT_W'(WIDTH);
        zero_o = (in_i == '0);
        // Scan upward so the highest set bit has the final say.
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (in_i[i]) begin
                cnt_o = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even.
// S1 unpacks, aligns and resolves specials; S2 adds; S3 normalises, rounds and packs.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W(EXP_W, MAN_W)-1:0] in_a,
    input  logic [W(EXP_W, MAN_W)-1:0] in_b,
    input  logic                       in_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W(EXP_W, MAN_W)-1:0] out_result,
    output logic                       out_overflow,
    output logic                       out_zero,
    output logic                       out_nan,
    output logic                       out_inexact
);

    localparam int unsigned WD  = W(EXP_W, MAN_W);
    localparam int unsigned DW  = MAN_W + 4;
    localparam int unsigned EW2 = EXP_W + 2;
    localparam int unsigned CW  = $clog2(DW + 1);
    localparam logic [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
    localparam logic [63:0] QNAN_WORD = qnan_word(EXP_W, MAN_W);

    logic             adv;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    fp_tag_e          tag1_q, tag1_d, tag2_q, tag2_d;
    logic             sign1_q, sign1_d, sign2_q, sign2_d, sub1_q, sub1_d;
    logic [EXP_W-1:0] exp1_q, exp1_d, exp2_q, exp2_d;
    logic [DW-1:0]    big1_q, big1_d, sml1_q, sml1_d;
    logic [DW:0]      sum2_q, sum2_d;
    logic [WD-1:0]    res_q, res_d;
    logic             ovf_q, ovf_d, zero_q, zero_d, nan_q, nan_d, inx_q, inx_d;

    // Whole pipeline advances together; stalls only when the output is held.
    assign adv      = !v3_q || out_ready;
    assign in_ready = adv;

    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
    logic [EXP_W-1:0] ea, eb, be, se, be_eff, se_eff, diff;
    logic [MAN_W-1:0] fa, fb, bf, sf;
    logic [DW-1:0]    bm, sm, sm_al;
    logic [2*DW-1:0]  sm_wide;
    fp_tag_e          tag_s1;
    logic             sign_s1;

    always_comb begin
        sa     = in_a[WD-1];
        ea     = in_a[WD-2:MAN_W];
        fa     = in_a[MAN_W-1:0];
        sb     = in_b[WD-1] ^ in_sub;
        eb     = in_b[WD-2:MAN_W];
        fb     = in_b[MAN_W-1:0];
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        a_zero = (ea == '0) && (fa == '0);
        b_zero = (eb == '0) && (fb == '0);
        swap   = in_b[WD-2:0] > in_a[WD-2:0];
        be     = swap ? eb : ea;
        bf     = swap ? fb : fa;
        se     = swap ? ea : eb;
        sf     = swap ? fa : fb;
        be_eff = (be == '0) ? EXP_W'(1) : be;
        se_eff = (se == '0) ? EXP_W'(1) : se;
        diff   = be_eff - se_eff;
        bm     = {|be, bf, 3'b000};
        sm     = {|se, sf, 3'b000};
        // Bits shifted below the sticky position are folded back into it.
        sm_wide = {sm, {DW{1'b0}}} >> diff;
        if (32'(diff) >= MAN_W + 3) begin
            sm_al = {{(DW-1){1'b0}}, |sm};
        end else begin
            sm_al = sm_wide[2*DW-1:DW] | {{(DW-1){1'b0}}, |sm_wide[DW-1:0]};
        end
        tag_s1  = NORM;
        sign_s1 = swap ? sb : sa;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            tag_s1  = QNAN;
            sign_s1 = 1'b0;
        end else if (a_inf || b_inf) begin
            tag_s1  = INF;
            sign_s1 = a_inf ? sa : sb;
        end else if (a_zero && b_zero) begin
            tag_s1  = ZERO;
            sign_s1 = sa & sb;
        end
    end

    logic [CW-1:0] lz;
    logic          sum_zero;

    fp_lzc #(
        .WIDTH (DW),
        .CNT_W (CW)
    ) u_lzc (
        .in_i   (sum2_q[DW-1:0]),
        .cnt_o  (lz),
        .zero_o (sum_zero)
    );

    logic [DW-1:0]    norm;
    logic [EW2-1:0]   e3, ef;
    logic [31:0]      lim, sh;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] frac3;
    logic             rnd_up, grs;
    logic [WD-1:0]    res_s3;
    logic             ovf_s3, zero_s3, nan_s3, inx_s3;

    always_comb begin
        // Left shift stops once the exponent reaches 1, yielding a subnormal.
        lim = 32'(exp2_q) - 32'd1;
        sh  = (32'(lz) > lim) ? lim : 32'(lz);
        if (sum2_q[DW]) begin
            norm = sum2_q[DW:1] | {{(DW-1){1'b0}}, sum2_q[0]};
            e3   = {2'b00, exp2_q} + EW2'(1);
        end else begin
            norm = sum2_q[DW-1:0] << sh;
            e3   = {2'b00, exp2_q} - EW2'(sh);
        end
        grs    = |norm[2:0];
        rnd_up = norm[2] && (norm[1] || norm[0] || norm[3]);
        mr     = {1'b0, norm[DW-1:3]} + (MAN_W+2)'(rnd_up);
        if (mr[MAN_W+1]) begin
            ef    = e3 + EW2'(1);
            frac3 = '0;
        end else begin
            ef    = mr[MAN_W] ? e3 : '0;
            frac3 = mr[MAN_W-1:0];
        end
        res_s3  = '0;
        ovf_s3  = 1'b0;
        zero_s3 = 1'b0;
        nan_s3  = 1'b0;
        inx_s3  = 1'b0;
        unique case (tag2_q)
            QNAN: begin
                res_s3 = QNAN_WORD[WD-1:0];
                nan_s3 = 1'b1;
            end
            INF:  res_s3 = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ZERO: begin
                res_s3  = {sign2_q, {(WD-1){1'b0}}};
                zero_s3 = 1'b1;
            end
            NORM: begin
                if (sum_zero && !sum2_q[DW]) begin
                    zero_s3 = 1'b1;
                end else if (ef >= EMAX) begin
                    res_s3 = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_s3 = 1'b1;
                    inx_s3 = grs;
                end else begin
                    res_s3 = {sign2_q, ef[EXP_W-1:0], frac3};
                    inx_s3 = grs;
                end
            end
        endcase
    end

    always_comb begin
        v1_d = v1_q;  tag1_d = tag1_q;  sign1_d = sign1_q;  sub1_d = sub1_q;
        exp1_d = exp1_q;  big1_d = big1_q;  sml1_d = sml1_q;
        v2_d = v2_q;  tag2_d = tag2_q;  sign2_d = sign2_q;  exp2_d = exp2_q;  sum2_d = sum2_q;
        v3_d = v3_q;  res_d = res_q;  ovf_d = ovf_q;  zero_d = zero_q;  nan_d = nan_q;
        inx_d = inx_q;
        if (adv) begin
            v1_d    = in_valid;
            tag1_d  = tag_s1;
            sign1_d = sign_s1;
            sub1_d  = sa ^ sb;
            exp1_d  = be_eff;
            big1_d  = bm;
            sml1_d  = sm_al;
            v2_d    = v1_q;
            tag2_d  = tag1_q;
            sign2_d = sign1_q;
            exp2_d  = exp1_q;
            sum2_d  = sub1_q ? ({1'b0, big1_q} - {1'b0, sml1_q})
                             : ({1'b0, big1_q} + {1'b0, sml1_q});
            v3_d    = v2_q;
            res_d   = res_s3;
            ovf_d   = ovf_s3;
            zero_d  = zero_s3;
            nan_d   = nan_s3;
            inx_d   = inx_s3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;  tag1_q <= NORM;  sign1_q <= 1'b0;  sub1_q <= 1'b0;
            exp1_q <= '0;  big1_q <= '0;  sml1_q <= '0;
            v2_q <= 1'b0;  tag2_q <= NORM;  sign2_q <= 1'b0;  exp2_q <= '0;  sum2_q <= '0;
            v3_q <= 1'b0;  res_q <= '0;  ovf_q <= 1'b0;  zero_q <= 1'b0;  nan_q <= 1'b0;
            inx_q <= 1'b0;
        end else begin
            v1_q <= v1_d;  tag1_q <= tag1_d;  sign1_q <= sign1_d;  sub1_q <= sub1_d;
            exp1_q <= exp1_d;  big1_q <= big1_d;  sml1_q <= sml1_d;
            v2_q <= v2_d;  tag2_q <= tag2_d;  sign2_q <= sign2_d;  exp2_q <= exp2_d;
            sum2_q <= sum2_d;
            v3_q <= v3_d;  res_q <= res_d;  ovf_q <= ovf_d;  zero_q <= zero_d;  nan_q <= nan_d;
            inx_q <= inx_d;
        end
    end

    assign out_valid    = v3_q;
    assign out_result   = res_q;
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;
    assign out_nan      = nan_q;
    assign out_inexact  = inx_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: a half-precision and a single-precision instance,
// with latency, rounding/special cases, backpressure and mid-stream reset.
module tb_fp_add_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        h_in_valid = 1'b0, h_in_sub = 1'b0, h_out_ready = 1'b1;
    logic [15:0] h_in_a = '0, h_in_b = '0;
    logic        h_in_ready, h_out_valid, h_ovf, h_zero, h_nan, h_inx;
    logic [15:0] h_out_result;

    logic        s_in_valid = 1'b0, s_in_sub = 1'b0, s_out_ready = 1'b1;
    logic [31:0] s_in_a = '0, s_in_b = '0;
    logic        s_in_ready, s_out_valid, s_ovf, s_zero, s_nan, s_inx;
    logic [31:0] s_out_result;

    // Expected {result, overflow, zero, nan, inexact}, pushed on acceptance.
    logic [19:0] qh[$];
    logic [35:0] qs[$];

    fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk (clk), .rst_n (rst_n), .in_valid (h_in_valid), .in_ready (h_in_ready),
        .in_a (h_in_a), .in_b (h_in_b), .in_sub (h_in_sub), .out_valid (h_out_valid),
        .out_ready (h_out_ready), .out_result (h_out_result), .out_overflow (h_ovf),
        .out_zero (h_zero), .out_nan (h_nan), .out_inexact (h_inx)
    );

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) u_dut_s (
        .clk (clk), .rst_n (rst_n), .in_valid (s_in_valid), .in_ready (s_in_ready),
        .in_a (s_in_a), .in_b (s_in_b), .in_sub (s_in_sub), .out_valid (s_out_valid),
        .out_ready (s_out_ready), .out_result (s_out_result), .out_overflow (s_ovf),
        .out_zero (s_zero), .out_nan (s_nan), .out_inexact (s_inx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (h_out_valid && h_out_ready) begin
            chk("h_sb_nonempty", 64'(qh.size() != 0), 64'd1);
            if (qh.size() != 0)
                chk("h_result", 64'({h_out_result, h_ovf, h_zero, h_nan, h_inx}),
                    64'(qh.pop_front()));
        end
        if (s_out_valid && s_out_ready) begin
            chk("s_sb_nonempty", 64'(qs.size() != 0), 64'd1);
            if (qs.size() != 0)
                chk("s_result", 64'({s_out_result, s_ovf, s_zero, s_nan, s_inx}),
                    64'(qs.pop_front()));
        end
    end

    task automatic send_h(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [19:0] e);
        int n = 0;
        @(negedge clk);
        h_in_a = a; h_in_b = b; h_in_sub = sub; h_in_valid = 1'b1;
        while (!h_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("h_accept_timeout", 64'(h_in_ready), 64'd1);
        else qh.push_back(e);
        @(posedge clk);
        #1 h_in_valid = 1'b0;
    endtask

    task automatic send_s(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [35:0] e);
        int n = 0;
        @(negedge clk);
        s_in_a = a; s_in_b = b; s_in_sub = sub; s_in_valid = 1'b1;
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("s_accept_timeout", 64'(s_in_ready), 64'd1);
        else qs.push_back(e);
        @(posedge clk);
        #1 s_in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (1) until out_valid rises.
    task automatic lat_h(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [19:0] e);
        int cyc;
        send_h(a, b, sub, e);
        cyc = 1;
        while (!h_out_valid && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("h_latency", 64'(cyc), 64'd3);
    endtask

    task automatic lat_s(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [35:0] e);
        int cyc;
        send_s(a, b, sub, e);
        cyc = 1;
        while (!s_out_valid && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("s_latency", 64'(cyc), 64'd3);
    endtask

    task automatic drain();
        int n = 0;
        while ((qh.size() != 0 || qs.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("h_drain", 64'(qh.size()), 64'd0);
        chk("s_drain", 64'(qs.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] held;
        #1;
        chk("rst_h_valid", 64'(h_out_valid), 64'd0);
        chk("rst_h_data", 64'({h_out_result, h_ovf, h_zero, h_nan, h_inx}), 64'd0);
        chk("rst_s_valid", 64'(s_out_valid), 64'd0);
        #22 rst_n = 1'b1;
        @(negedge clk);
        chk("h_in_ready_after_rst", 64'(h_in_ready), 64'd1);

        lat_h(16'h3C00, 16'h4000, 1'b0, {16'h4200, 4'b0000});
        lat_s(32'h3F800000, 32'h40000000, 1'b0, {32'h40400000, 4'b0000});
        drain();

        send_h(16'h3C00, 16'h3C00, 1'b1, {16'h0000, 4'b0100});
        send_h(16'h8000, 16'h8000, 1'b0, {16'h8000, 4'b0100});
        send_h(16'h3C00, 16'h1000, 1'b0, {16'h3C00, 4'b0001});
        send_h(16'h3C01, 16'h1000, 1'b0, {16'h3C02, 4'b0001});
        send_h(16'h0001, 16'h0001, 1'b0, {16'h0002, 4'b0000});
        send_h(16'h7BFF, 16'h7BFF, 1'b0, {16'h7C00, 4'b1000});
        send_h(16'h7C00, 16'h7C00, 1'b1, {16'h7E00, 4'b0010});
        send_h(16'h7C01, 16'h3C00, 1'b0, {16'h7E00, 4'b0010});
        send_h(16'h7C00, 16'h3C00, 1'b0, {16'h7C00, 4'b0000});
        send_h(16'h3C00, 16'h4000, 1'b1, {16'hBC00, 4'b0000});
        send_h(16'h0000, 16'h8000, 1'b0, {16'h0000, 4'b0100});
        send_h(16'h8001, 16'h0001, 1'b0, {16'h0000, 4'b0100});

        send_s(32'h3F800000, 32'h3F800000, 1'b1, {32'h00000000, 4'b0100});
        send_s(32'h80000000, 32'h80000000, 1'b0, {32'h80000000, 4'b0100});
        send_s(32'h3F800000, 32'h33800000, 1'b0, {32'h3F800000, 4'b0001});
        send_s(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, {32'h7F800000, 4'b1000});
        send_s(32'h7F800000, 32'h7F800000, 1'b1, {32'h7FC00000, 4'b0010});
        drain();

        fork
            begin
                send_h(16'h3C00, 16'h4000, 1'b0, {16'h4200, 4'b0000});
                send_h(16'h3C00, 16'h1000, 1'b0, {16'h3C00, 4'b0001});
                send_h(16'h3C01, 16'h1000, 1'b0, {16'h3C02, 4'b0001});
                send_h(16'h0001, 16'h0001, 1'b0, {16'h0002, 4'b0000});
                send_h(16'h4000, 16'h4000, 1'b0, {16'h4400, 4'b0000});
                send_h(16'h3C00, 16'h4000, 1'b1, {16'hBC00, 4'b0000});
            end
            begin
                int n = 0;
                while (!h_out_valid && n < 50) begin
                    @(posedge clk);
                    #2 n++;
                end
                chk("bp_out_valid_seen", 64'(h_out_valid), 64'd1);
                h_out_ready = 1'b0;
                held = {h_out_result, h_ovf, h_zero, h_nan, h_inx};
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(h_in_ready), 64'd0);
                    chk("bp_valid_hold", 64'(h_out_valid), 64'd1);
                    chk("bp_data_hold", 64'({h_out_result, h_ovf, h_zero, h_nan, h_inx}),
                        64'(held));
                end
                @(posedge clk);
                #2 h_out_ready = 1'b1;
            end
        join
        drain();

        send_h(16'h3C00, 16'h4000, 1'b0, {16'h4200, 4'b0000});
        send_h(16'h3C00, 16'h3C00, 1'b0, {16'h4000, 4'b0000});
        send_h(16'h4000, 16'h4000, 1'b0, {16'h4400, 4'b0000});
        chk("inflight_valid", 64'(h_out_valid), 64'd1);
        qh.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(h_out_valid), 64'd0);
        chk("rst_mid_data", 64'({h_out_result, h_ovf, h_zero, h_nan, h_inx}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 64'(h_out_valid), 64'd0);
        lat_h(16'h3C01, 16'h1000, 1'b0, {16'h3C02, 4'b0001});
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor, the successor to the combinational half-precision adder in the vertex-shader datapath. It is generic in exponent and mantissa width, has an add/subtract mode input and round-to-nearest-even rounding, and handles subnormals, infinities and NaN. A three-stage pipeline with valid/ready handshakes lets it sit between the vertex-attribute fetch and the transform units.

## Interface
Parameters:
- EXP_W, default 5: exponent width in bits; bias = 2^(EXP_W-1)-1.
- MAN_W, default 10: stored fraction width in bits; word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair is valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_a, in_b  in  W  operands, {sign, exp, frac}.
- in_sub  in  1  0 = a+b, 1 = a−b (negates in_b's sign).
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  W  rounded sum.
- out_overflow  out  1  finite inputs rounded to ±inf.
- out_zero  out  1  result is ±0.
- out_nan  out  1  result is NaN.
- out_inexact  out  1  a nonzero guard, round or sticky bit was discarded.

## Operation
- S1 (unpack/align):
  - Hidden bit is 1 if exp≠0. Subnormal effective exponent is 1.
  - Swap so the magnitude of A is ≥ the magnitude of B.
  - Shift B right by the exponent difference into a MAN_W+4 datapath (hidden, frac, G, R, S). Bits shifted past S OR into S.
  - Exponent differences ≥ MAN_W+3 collapse B to sticky only.
- S2 (add): effective subtract = sign_a XOR sign_b'. Add or subtract the magnitudes; the carry-out is kept.
- S3 (normalise/round/pack):
  - Carry → shift right 1, exponent+1, with sticky preserved.
  - Otherwise leading-zero count, then shift left, limited so the exponent does not go below 1. The result becomes subnormal when the limit is hit.
  - Round to nearest, ties to even. A rounding carry may bump the exponent.
  - Exponent reaching 2^EXP_W−1 → ±inf, out_overflow=1.
- Specials, resolved in S1 and carried as a tag:
  - Any NaN input, or inf−inf → canonical quiet NaN {0, all-ones exp, MSB frac=1, rest 0}, out_nan=1.
  - A single inf → that inf, out_overflow=0.
  - Exact cancellation of finite inputs → +0.
  - (−0)+(−0) → −0.
- Flags are mutually consistent: out_nan excludes out_zero and out_overflow; out_inexact=0 for specials.

## Timing
- Latency: 3 cycles from an accepted input to out_valid, with no backpressure.
- Throughput: 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Pipeline-wide stall: in_ready = !out_valid || out_ready. All stages advance together.
  - Bubbles are not collapsed.
- While out_valid && !out_ready: out_result and all flags hold stable. Input changes do not propagate.
- Order of results equals order of acceptance.
- in_ready has no combinational dependence on in_valid.
- Reset (async assert, takes effect at once, including mid-operation):
  - All stage valid bits = 0; in-flight operations are discarded.
  - out_valid=0; out_result and all flags = 0.
  - in_ready=1 from the first cycle after deassertion.

## Structure
- Shared package fp_pkg holds:
  - field-width helpers, BIAS(EXP_W) and W(EXP_W,MAN_W);
  - the special-case tag enum (NORM, ZERO, INF, QNAN);
  - the canonical-QNaN constant function.
- One sub-module, fp_lzc: parametrised leading-zero counter used in S3, purely combinational.
- Pipeline registers live in fp_add_pipe itself.

## Test plan
- 0x3C00 + 0x4000 (1.0+2.0), in_sub=0 → 0x4200; all flags 0; out_valid exactly 3 cycles after acceptance.
- 0x3C00 − 0x3C00 → 0x0000, out_zero=1. Also 0x8000 + 0x8000 → 0x8000, out_zero=1.
- Rounding and subnormals:
  - 0x3C00 + 0x1000 (tie) → 0x3C00, out_inexact=1.
  - 0x3C01 + 0x1000 → 0x3C02, out_inexact=1.
  - 0x0001 + 0x0001 → 0x0002, out_inexact=0.
- Overflow and specials:
  - 0x7BFF + 0x7BFF → 0x7C00, out_overflow=1.
  - 0x7C00 − 0x7C00 → 0x7E00, out_nan=1.
  - 0x7C01 + 0x3C00 → 0x7E00, out_nan=1.
- Backpressure: stream 6 ops with out_ready=0 for 5 cycles mid-stream.
  - in_ready=0 while stalled.
  - Output holds stable.
  - All 6 results arrive in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight.
  - out_valid=0 and outputs = 0 immediately.
  - After release, no stale result appears; a new op completes in 3 cycles.
- Repeat the first three scenarios with EXP_W=8, MAN_W=23, e.g. 0x3F800000 + 0x40000000 → 0x40400000.
